// File: rtl/ysyx_220066_pkg.sv
// Shared types and constants for the ysyx_220066 IF-stage fetch sequencer.
package ysyx_220066_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ysyx_220066_fetch_buf.sv
// One-entry holding register for the fetched instruction handed to decode.
// pc/inst keep their last value whenever the entry is invalid.
module ysyx_220066_fetch_buf
  import ysyx_220066_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [AW-1:0]     i_load_pc,
  input  logic [INST_W-1:0] i_load_inst,
  input  logic              i_consume,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [AW-1:0]     o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [AW-1:0]     r_pc;
  logic [INST_W-1:0] r_inst;

  // Valid flag: flush beats load, load beats consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Payload captured only on a (non-flushed) load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_inst <= '0;
    end else if (i_load && !i_flush) begin
      r_pc   <= i_load_pc;
      r_inst <= i_load_inst;
    end else begin
      r_pc   <= r_pc;
      r_inst <= r_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/ysyx_220066_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues one IMEM request at a time,
// buffers the returned instruction for decode and applies EX redirects.
module ysyx_220066_fetch_ctrl
  import ysyx_220066_pkg::*;
#(
  parameter int               XLEN     = ysyx_220066_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(ysyx_220066_pkg::RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic            w_buf_load;
  logic            w_buf_consume;
  logic            w_buf_flush;
  logic            w_buf_valid;

  // State, PC and kill-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= r_kill ? w_kill_nxt : w_kill_nxt;
    end
  end

  // Next-state logic; a redirect outranks every other event in its cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_kill_nxt    = r_kill;
    w_buf_load    = 1'b0;
    w_buf_consume = 1'b0;
    w_buf_flush   = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_buf_flush = 1'b1;
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) begin
            w_state_nxt = ST_WAIT;
            w_kill_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            w_state_nxt = ST_REQ;
            w_kill_nxt  = 1'b0;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end
        ST_HOLD: w_state_nxt = ST_REQ;
        default: begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid && r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else if (imem_rsp_valid) begin
            w_buf_load  = 1'b1;
            w_pc_nxt    = r_pc + PC_STEP;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (w_buf_valid && if_ready) begin
            w_buf_consume = 1'b1;
            w_state_nxt   = ST_REQ;
          end else begin
            w_state_nxt   = ST_HOLD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b0;
        end
      endcase
    end
  end

  ysyx_220066_fetch_buf #(
    .AW(XLEN)
  ) u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_buf_load),
    .i_load_pc   (r_pc),
    .i_load_inst (imem_rsp_data),
    .i_consume   (w_buf_consume),
    .i_flush     (w_buf_flush),
    .o_valid     (w_buf_valid),
    .o_pc        (if_pc),
    .o_inst      (if_inst)
  );

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_buf_valid;

endmodule

// File: tb/tb_ysyx_220066_fetch_ctrl.sv
// Directed self-checking bench for ysyx_220066_fetch_ctrl.
module tb_ysyx_220066_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  int n_checks;
  int n_pass;

  ysyx_220066_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if_ready       = 1'b0;
    step();
    step();
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_inst", {32'd0, if_inst}, 64'd0);
    rst_n = 1'b1;

    // basic fetch
    step();
    chk("t1_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t1_addr", imem_req_addr, 64'h8000_0000);
    step();
    chk("t1_wait_noreq", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    chk("t1_if_valid", {63'd0, if_valid}, 64'd1);
    chk("t1_if_pc", if_pc, 64'h8000_0000);
    chk("t1_if_inst", {32'd0, if_inst}, 64'h13);
    chk("t1_next_addr", imem_req_addr, 64'h8000_0004);

    // stall in HOLD
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {63'd0, if_valid}, 64'd1);
      chk("t2_hold_pc", if_pc, 64'h8000_0000);
      chk("t2_hold_inst", {32'd0, if_inst}, 64'h13);
      chk("t2_hold_noreq", {63'd0, imem_req_valid}, 64'd0);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("t2_if_valid_clr", {63'd0, if_valid}, 64'd0);
    chk("t2_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t2_addr", imem_req_addr, 64'h8000_0004);

    // redirect in REQ with ready=1
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    chk("t3_wait_addr", imem_req_addr, 64'h8000_1000);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef;
    step();
    imem_rsp_valid = 1'b0;
    chk("t3_dropped", {63'd0, if_valid}, 64'd0);
    chk("t3_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t3_addr", imem_req_addr, 64'h8000_1000);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    chk("t3_if_valid", {63'd0, if_valid}, 64'd1);
    chk("t3_if_pc", if_pc, 64'h8000_1000);
    chk("t3_if_inst", {32'd0, if_inst}, 64'h0010_0093);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("t3_next_addr", imem_req_addr, 64'h8000_1004);

    // redirect in WAIT, late response
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    chk("t4_wait_noreq", {63'd0, imem_req_valid}, 64'd0);
    chk("t4_addr", imem_req_addr, 64'h8000_2000);
    step();
    step();
    chk("t4_still_wait", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0bad;
    step();
    imem_rsp_valid = 1'b0;
    chk("t4_dropped", {63'd0, if_valid}, 64'd0);
    chk("t4_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t4_req_addr", imem_req_addr, 64'h8000_2000);
    step();
    chk("t4_one_req", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;
    step();
    imem_rsp_valid = 1'b0;
    chk("t4_if_valid", {63'd0, if_valid}, 64'd1);
    chk("t4_if_pc", if_pc, 64'h8000_2000);
    chk("t4_if_inst", {32'd0, if_inst}, 64'h0020_0113);

    // redirect in HOLD with simultaneous handshake
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    step();
    if_ready = 1'b0; redirect_valid = 1'b0;
    chk("t5_if_valid", {63'd0, if_valid}, 64'd0);
    chk("t5_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t5_addr", imem_req_addr, 64'h8000_3000);

    // async reset in WAIT, then stale response
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("t6_rst_addr", imem_req_addr, 64'h8000_0000);
    chk("t6_rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("t6_rst_if_pc", if_pc, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    step();
    rst_n = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("t6_ignored", {63'd0, if_valid}, 64'd0);
    chk("t6_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t6_addr", imem_req_addr, 64'h8000_0000);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    chk("t6_if_pc", if_pc, 64'h8000_0000);
    chk("t6_if_inst", {32'd0, if_inst}, 64'h13);

    // redirect in REQ with ready=0, then PC wrap
    if_ready = 1'b1;
    step();
    if_ready = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t7_stay_req", {63'd0, imem_req_valid}, 64'd1);
    chk("t7_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0193;
    step();
    imem_rsp_valid = 1'b0;
    chk("t7_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7_wrap_addr", imem_req_addr, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
